// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage pipelined IEEE-754 style adder/subtractor.
//   S1 unpack / compare / align, S2 add / subtract, S3 normalise / round / pack.
//   Round-to-nearest-even, canonical quiet NaN, flags {invalid, overflow,
//   underflow, inexact} travel with the result.
// Configuration macro: FP_ADD_SUBNORMAL_EN
//   defined   -> subnormal operands and results are supported
//   undefined -> subnormal operands read as signed zero, tiny results flush
module fp_add_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op_sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

`ifdef FP_ADD_SUBNORMAL_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam int W       = 1 + EXP_W + MAN_W;
  localparam int SW      = MAN_W + 4;          // hidden, fraction, G, R, S
  localparam int SH_MAX  = MAN_W + 3;          // alignment shift saturation
  localparam int EXP_TOP = (1 << EXP_W) - 1;   // all-ones exponent as int

  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic             nan;
    logic             snan;
    logic             inf;
    logic             flushed;   // non-zero subnormal read as zero
    logic [EXP_W-1:0] exp;       // effective exponent
    logic [MAN_W:0]   sig;       // hidden bit + fraction
  } unpacked_t;

  typedef struct packed {
    logic             special;
    logic [W-1:0]     spec_res;
    logic             spec_invalid;
    logic             sign;
    logic             eff_sub;
    logic             flushed;
    logic [EXP_W-1:0] exp;
    logic [SW-1:0]    sx;
    logic [SW-1:0]    sy;
  } s1_t;

  typedef struct packed {
    logic             special;
    logic [W-1:0]     spec_res;
    logic             spec_invalid;
    logic             sign;
    logic             eff_sub;
    logic             flushed;
    logic [EXP_W-1:0] exp;
    logic [SW:0]      sum;       // carry + SW bits
  } s2_t;

  function automatic unpacked_t unpack(input logic [W-1:0] v, input logic flip);
    unpacked_t        u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e         = v[W-2:MAN_W];
    f         = v[MAN_W-1:0];
    u.sign    = v[W-1] ^ flip;
    u.nan     = (e == EXP_ONES) && (f != '0);
    u.snan    = u.nan && !f[MAN_W-1];
    u.inf     = (e == EXP_ONES) && (f == '0);
    u.flushed = 1'b0;
    if (e != '0) begin
      u.exp = e;
      u.sig = {1'b1, f};
    end else if (SUB_EN) begin
      u.exp = {{(EXP_W-1){1'b0}}, 1'b1};
      u.sig = {1'b0, f};
    end else begin
      u.exp     = '0;
      u.sig     = '0;
      u.flushed = (f != '0);
    end
    return u;
  endfunction

  // Number of leading zeros above the hidden-bit position.
  function automatic int lzc(input logic [SW-1:0] v);
    int n;
    n = SW;
    for (int i = 0; i < SW; i++) begin
      if (v[i]) n = SW - 1 - i;
    end
    return n;
  endfunction

  logic v1, v2, v3;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign out_valid = v3;
  assign in_ready  = out_ready | ~v3;

  // ---------------- S1: unpack, order by magnitude, align ----------------
  unpacked_t        ua, ub;
  logic             a_big;
  logic [MAN_W:0]   sig_x, sig_y;
  logic [EXP_W-1:0] exp_y;
  logic [SW-1:0]    ext_y, shifted;
  logic             lost;
  logic             inf_clash;
  int               diff;

  // Select the larger operand and shift the smaller one into alignment.
  // NOTE: every variable gets a default at the top of an always_comb so no path can infer a latch.
  always_comb begin
    s1_d      = '0;
    ua        = unpack(a, 1'b0);
    ub        = unpack(b, op_sub);
    a_big     = {ua.exp, ua.sig} >= {ub.exp, ub.sig};
    sig_x     = a_big ? ua.sig : ub.sig;
    sig_y     = a_big ? ub.sig : ua.sig;
    exp_y     = a_big ? ub.exp : ua.exp;
    inf_clash = ua.inf & ub.inf & (ua.sign ^ ub.sign);

    s1_d.eff_sub = ua.sign ^ ub.sign;
    s1_d.sign    = a_big ? ua.sign : ub.sign;
    s1_d.flushed = ua.flushed | ub.flushed;
    s1_d.exp     = a_big ? ua.exp : ub.exp;

    diff = int'(s1_d.exp) - int'(exp_y);
    if (diff > SH_MAX) diff = SH_MAX;
    ext_y   = {sig_y, 3'b000};
    shifted = ext_y >> diff;
    lost    = |(ext_y & ~({SW{1'b1}} << diff));
    s1_d.sx = {sig_x, 3'b000};
    s1_d.sy = {shifted[SW-1:1], shifted[0] | lost};

    // NaN and infinity outcomes bypass the arithmetic datapath.
    if (ua.nan || ub.nan || inf_clash) begin
      s1_d.special      = 1'b1;
      s1_d.spec_res     = QNAN;
      s1_d.spec_invalid = ua.snan | ub.snan | inf_clash;
    end else if (ua.inf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_res = {ua.sign, EXP_ONES, {MAN_W{1'b0}}};
    end else if (ub.inf) begin
      s1_d.special  = 1'b1;
      s1_d.spec_res = {ub.sign, EXP_ONES, {MAN_W{1'b0}}};
    end
  end

  // ---------------- S2: magnitude add or subtract ----------------
  // Larger minus smaller keeps the difference non-negative.
  always_comb begin
    s2_d.special      = s1_q.special;
    s2_d.spec_res     = s1_q.spec_res;
    s2_d.spec_invalid = s1_q.spec_invalid;
    s2_d.sign         = s1_q.sign;
    s2_d.eff_sub      = s1_q.eff_sub;
    s2_d.flushed      = s1_q.flushed;
    s2_d.exp          = s1_q.exp;
    s2_d.sum          = s1_q.eff_sub ? ({1'b0, s1_q.sx} - {1'b0, s1_q.sy})
                                     : ({1'b0, s1_q.sx} + {1'b0, s1_q.sy});
  end

  // ---------------- S3: normalise, round, pack ----------------
  logic [W-1:0]   res_d;
  logic [3:0]     flags_d;
  logic [SW-1:0]  norm;
  logic [MAN_W:0] mant, mant_f;
  logic [MAN_W+1:0] mant_r;
  logic           guard, rs, rnd, tiny, inexact;
  int             exp_i, sh;

  // Normalise the sum, round to nearest-even and resolve the exception cases.
  always_comb begin
    res_d   = '0;
    flags_d = '0;
    norm    = '0;
    exp_i   = int'(s2_q.exp);
    sh      = 0;
    if (s2_q.sum[SW]) begin
      norm  = {s2_q.sum[SW:2], s2_q.sum[1] | s2_q.sum[0]};
      exp_i = exp_i + 1;
    end else begin
      sh = lzc(s2_q.sum[SW-1:0]);
      if (sh > exp_i - 1) sh = exp_i - 1;   // stop at the minimum normal exponent
      norm  = s2_q.sum[SW-1:0] << sh;
      exp_i = exp_i - sh;
    end
    tiny    = ~norm[SW-1];
    guard   = norm[2];
    rs      = norm[1] | norm[0];
    inexact = guard | rs | s2_q.flushed;
    mant    = norm[SW-1:3];
    rnd     = guard & (rs | mant[0]);
    mant_r  = {1'b0, mant} + {{(MAN_W+1){1'b0}}, rnd};
    if (mant_r[MAN_W+1]) begin
      mant_f = mant_r[MAN_W+1:1];
      exp_i  = exp_i + 1;
    end else begin
      mant_f = mant_r[MAN_W:0];
    end

    if (s2_q.special) begin
      res_d   = s2_q.spec_res;
      flags_d = {s2_q.spec_invalid, 3'b000};
    end else if (s2_q.sum == '0) begin
      // Exact cancellation gives +0; equal-signed zeros keep their sign.
      res_d   = {s2_q.sign & ~s2_q.eff_sub, {(W-1){1'b0}}};
      flags_d = {2'b00, s2_q.flushed, s2_q.flushed};
    end else if (exp_i >= EXP_TOP) begin
      res_d   = {s2_q.sign, EXP_ONES, {MAN_W{1'b0}}};
      flags_d = 4'b0101;
    end else if (tiny && !SUB_EN) begin
      res_d   = {s2_q.sign, {(W-1){1'b0}}};
      flags_d = 4'b0011;
    end else begin
      res_d   = {s2_q.sign, (mant_f[MAN_W] ? EXP_W'(exp_i) : {EXP_W{1'b0}}),
                 mant_f[MAN_W-1:0]};
      flags_d = {2'b00, tiny & inexact, inexact};
    end
  end

  // Pipeline registers: every stage moves together, or all hold on a stall.
  // NOTE: non-blocking assignments make each stage capture the pre-edge value of the one before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      v2     <= 1'b0;
      v3     <= 1'b0;
      s1_q   <= '0;
      s2_q   <= '0;
      result <= '0;
      flags  <= '0;
    end else if (in_ready) begin
      v1     <= in_valid;
      s1_q   <= s1_d;
      v2     <= v1;
      s2_q   <= s2_d;
      v3     <= v2;
      result <= res_d;
      flags  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed checks of fp_add_pipe in single-precision layout.
// Expected values are hand-computed; the default build has
// FP_ADD_SUBNORMAL_EN undefined.
module tb_fp_add_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        op_sub = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid;
  logic [31:0] result;
  logic [3:0]  flags;

  int n_vec = 0;
  int n_err = 0;

  // Floats 1.0 .. 12.0
  logic [31:0] fl [0:11] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000};

  always #5 clk = ~clk;

  fp_add_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op_sub    (op_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One isolated operation with out_ready held high; checks latency, result, flags.
  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic sub, input logic [31:0] exp_res, input logic [3:0] exp_fl);
    int cycles;
    @(negedge clk);
    out_ready = 1'b1;
    a = va; b = vb; op_sub = sub; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cycles = 1;
    while (!out_valid && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, "_latency"}, cycles, 32'd3);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_flags"}, {28'd0, flags}, {28'd0, exp_fl});
  endtask

  initial begin
    int          sent, recv, cyc, extra;
    bit          stall_prev, saw_valid;
    logic [31:0] hold_res;
    logic [3:0]  hold_fl;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {28'd0, flags}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Directed single operations
    run_op("one_plus_one",  32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000);
    run_op("one_minus_one", 32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
    run_op("tie_even",      32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
    run_op("above_tie",     32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 4'b0001);
    run_op("overflow",      32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
    run_op("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("qnan_in",       32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000);
    run_op("snan_in",       32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 4'b1000);
    run_op("inf_plus_fin",  32'hFF800000, 32'h3F800000, 1'b0, 32'hFF800000, 4'b0000);
    run_op("neg_zeros",     32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
    run_op("cancel_shift",  32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 4'b0000);
    run_op("neg_result",    32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000);
`ifdef FP_ADD_SUBNORMAL_EN
    run_op("tiny_diff",     32'h00800001, 32'h00800000, 1'b1, 32'h00000001, 4'b0000);
    run_op("denorm_in",     32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000);
`else
    run_op("tiny_flush",    32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'b0011);
    run_op("denorm_in",     32'h00000001, 32'h00000001, 1'b0, 32'h00000000, 4'b0011);
`endif

    // Back-to-back stream of 10 with out_ready pattern 1,0,0,1
    sent = 0; recv = 0; cyc = 0; stall_prev = 1'b0;
    hold_res = '0; hold_fl = '0;
    while (recv < 10 && cyc < 200) begin
      @(negedge clk);
      if (stall_prev) begin
        check("stall_result", result, hold_res);
        check("stall_flags", {28'd0, flags}, {28'd0, hold_fl});
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 10);
      a         = fl[(sent < 10) ? sent : 0];
      b         = 32'h3F800000;
      op_sub    = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        check("stream_result", result, fl[recv + 1]);
        check("stream_flags", {28'd0, flags}, 32'd0);
        recv++;
      end
      stall_prev = out_valid && !out_ready;
      hold_res   = result;
      hold_fl    = flags;
      if (in_valid && in_ready) sent++;
      cyc++;
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_count", recv, 32'd10);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    check("stream_no_dup", extra, 32'd0);

    // Reset with two operations in flight, first one parked at the output
    @(negedge clk);
    out_ready = 1'b0;
    a = 32'h3F800000; b = 32'h3F800000; op_sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 32'h40000000;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_out_valid", {31'd0, out_valid}, 32'd1);
    check("pre_rst_in_ready", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_result", result, 32'd0);
    check("async_rst_flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("post_rst_no_stale", {31'd0, saw_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
